// File: rtl/uart_rx_data_sampler.sv
// Oversampling front end of the UART receiver: edge/bit counters plus a 3-sample majority vote per bit.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer before sampling.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  samp_en,
  output logic                  sampled_bit,
  output logic                  sample_done,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  err_prescale
);

  logic                  rx_s;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_done_q, sample_done_d;
  logic                  err_prescale_q, err_prescale_d;
  logic [2:0]            samp_q, samp_d;

  logic [PRESCALE_W-1:0] half, half_m1, half_p1, last_edge;
  logic                  active;
  logic                  at_wrap;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], RX_IN};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  always_comb begin
    half      = Prescale >> 1;
    half_m1   = half - PRESCALE_W'(1);
    half_p1   = half + PRESCALE_W'(1);
    last_edge = Prescale - PRESCALE_W'(1);
    // The legality flag is registered, so a newly illegal Prescale stalls counting one edge later.
    active    = samp_en & ~err_prescale_q;
    at_wrap   = (edge_cnt_q >= last_edge);

    err_prescale_d = !((Prescale == PRESCALE_W'(8)) ||
                       (Prescale == PRESCALE_W'(16)) ||
                       (Prescale == PRESCALE_W'(32)));

    edge_cnt_d    = '0;
    bit_cnt_d     = '0;
    samp_d        = samp_q;
    sampled_bit_d = sampled_bit_q;
    sample_done_d = 1'b0;

    if (active) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + PRESCALE_W'(1);
      bit_cnt_d  = bit_cnt_q;
      if (at_wrap && (bit_cnt_q != '1)) begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end

      if (edge_cnt_q == half_m1) samp_d[0] = rx_s;
      if (edge_cnt_q == half)    samp_d[1] = rx_s;
      if (edge_cnt_q == half_p1) begin
        samp_d[2]     = rx_s;
        // Vote on the next sample set so the third sample counts in the same edge.
        sampled_bit_d = (samp_d[0] & samp_d[1]) | (samp_d[0] & samp_d[2]) |
                        (samp_d[1] & samp_d[2]);
        sample_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      sampled_bit_q  <= 1'b1;
      sample_done_q  <= 1'b0;
      err_prescale_q <= 1'b0;
      samp_q         <= 3'b111;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_done_q  <= sample_done_d;
      err_prescale_q <= err_prescale_d;
      samp_q         <= samp_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_done  = sample_done_q;
  assign err_prescale = err_prescale_q;

endmodule

// File: doc/uart_rx_data_sampler.md
# uart_rx_data_sampler

Oversampling front end of the UART receiver. Counts RX oversampling edges and frame bits and takes three samples of the serial line around each bit centre. It produces one majority-voted `sampled_bit` per bit period, plus a one-cycle `sample_done` strobe. `sampled_bit` feeds the start-bit check, parity check and stop check stages; `edge_cnt` and `bit_cnt` feed the RX FSM.

## Interface
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_cnt`.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.
- `CLK`, input, 1: RX oversampling clock.
- `RST`, input, 1: asynchronous, active-low reset.
- `RX_IN`, input, 1: serial line, idle high.
- `Prescale`, input, PRESCALE_W: oversampling ratio. Only 8, 16 and 32 are legal.
- `samp_en`, input, 1: from the RX FSM. High means counting and sampling are active.
- `sampled_bit`, output, 1: majority vote of the last three samples. Held between updates.
- `sample_done`, output, 1: one-cycle pulse when `sampled_bit` is updated.
- `edge_cnt`, output, PRESCALE_W: oversampling edge counter within the current bit.
- `bit_cnt`, output, BIT_CNT_W: number of completed bit periods since `samp_en` rose.
- `err_prescale`, output, 1: high while `Prescale` is illegal.

## Operation
- **Reset (`RST`=0, asynchronous):**
  - `edge_cnt`=0, `bit_cnt`=0.
  - `sample_done`=0, `err_prescale`=0.
  - `sampled_bit`=1 (idle level).
  - Sample registers = 3'b111.
  - Synchronizer flops = 1.
- **Legality:** `err_prescale` is a registered compare of `Prescale` against {8, 16, 32}.
  - While it is 1: both counters are held at 0, no samples are taken and `sample_done` stays 0.
  - `sampled_bit` holds its last value while `err_prescale` is 1.
- **Counters disabled:** with `samp_en`=0, `edge_cnt` and `bit_cnt` clear to 0 on the next edge. `sampled_bit` holds.
- **Edge counter:** with `samp_en`=1 and a legal `Prescale`, `edge_cnt` increments each cycle from 0 to `Prescale`-1, then wraps to 0.
- **Bit counter:**
  - Increments on each `edge_cnt` wrap.
  - Saturates at all-ones and does not wrap.
  - Frame length is the FSM's decision.
- **Sampling:** let H = `Prescale`/2.
  - `rx_s` (defined under Configuration) is captured into sample registers s0, s1, s2 on the cycles where `edge_cnt` = H-1, H and H+1.
  - For `Prescale`=8 that is counts 3, 4 and 5.
- **Vote:** on the cycle where `edge_cnt` = H+1, the edge also loads `sampled_bit` = majority(s0, s1, s2), using the s2 value being captured, and sets `sample_done`=1 for exactly one cycle.
  - Both are therefore visible while `edge_cnt` = H+2.
- **`samp_en` rise:** counting starts at `edge_cnt`=0 on the first enabled cycle. No partial-bit carry-over.
- **`samp_en` fall mid-bit:** counters clear and any pending vote is discarded, so no `sample_done` occurs. Sample registers are not cleared.
- **`Prescale` change mid-bit:** not supported. The FSM changes it only while `samp_en`=0.
  - If it changes anyway to another legal value, counting continues against the new value.
  - If `edge_cnt` already equals or exceeds the new `Prescale`-1, it wraps to 0 on the next edge.

## Timing
- Vote latency: `sampled_bit`/`sample_done` appear 3 cycles after the first sample edge.
- Counted from `samp_en` rising, `sample_done` is first high at cycle H+2; cycle 0 is the first enabled cycle.
- `RX_IN` to sample latency: 2 cycles with `UART_RX_SYNC_EN`, 0 without.
- All outputs are registered. There is no combinational path from an input to an output.
- One `sample_done` per bit period.
- `bit_cnt` increments on the edge after `edge_cnt` = `Prescale`-1.

## Configuration
- Macro: `UART_RX_SYNC_EN`.
- **Defined:** `RX_IN` passes through a 2-flop synchronizer with reset value 1, and `rx_s` is the second flop.
- **Undefined:** `rx_s` = `RX_IN` directly. Use only when `RX_IN` is already synchronous to `CLK`.
- All other behaviour is identical in both builds.

## Test plan
- **Sampling position:** `Prescale`=8, `RX_IN`=0 held, `samp_en`=1 → `sample_done` pulses at `edge_cnt`=6 with `sampled_bit`=0. `bit_cnt` is 1 after 8 cycles and 2 after 16.
- **Glitch rejection:** `Prescale`=16 with only sample s1 (`edge_cnt`=8) driven 1 → `sampled_bit`=0. With s1 and s2 driven 1 → `sampled_bit`=1.
- **Illegal prescale:** `Prescale`=10 → `err_prescale`=1, `edge_cnt`=0 and `bit_cnt`=0 held, no `sample_done` over 40 cycles. Switching to 32 clears `err_prescale` next cycle.
- **Enable drop:** `samp_en` falls at `edge_cnt`=4 with `Prescale`=8 → no `sample_done`, counters 0 next cycle, `sampled_bit` unchanged.
- **Async reset mid-bit:** `RST` asserted mid-bit between clock edges → all outputs immediately at reset values (`sampled_bit`=1). After release, counting restarts from 0.
- **Saturation:** `Prescale`=8, `samp_en` held for 20 bit periods → `bit_cnt` stops at 15, `edge_cnt` keeps wrapping, and `sample_done` pulses every 8 cycles.
